// File: rtl/sc_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sc_fifo_pkg
//
// Shared definitions for the single-clock FIFO stream adapters.
//   MAX_FIFO_LATENCY  largest supported FIFO read latency (output register on)
//   DEF_DWIDTH        default word width used across the datapath
//   word_t            default-width data word
//   buf_depth()       prefetch buffer entries needed to hide a read latency
//   cnt_width()       width of an occupancy counter for that buffer
//   ptr_width()       width of a circular-buffer pointer for a given depth
// ----------------------------------------------------------------------------
package sc_fifo_pkg;

    localparam int MAX_FIFO_LATENCY = 2;
    localparam int DEF_DWIDTH       = 8;

    typedef logic [DEF_DWIDTH-1:0] word_t;

    // One entry per outstanding read plus one for the word being presented,
    // which is what lets the stream run at one word per cycle.
    function automatic int buf_depth(input int fifo_latency);
        return fifo_latency + 1;
    endfunction

    // The counter must be able to represent a completely full buffer.
    function automatic int cnt_width(input int fifo_latency);
        return $clog2(buf_depth(fifo_latency) + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sc_stream_buf.sv
// ----------------------------------------------------------------------------
// sc_stream_buf
//
// Small circular register buffer that holds words captured from the FIFO
// read port and presents the oldest one as a registered stream head.
//
// Ports:
//   clock      system clock, rising edge
//   rst        synchronous active-high reset (pointers, count, head register)
//   push       write push_data at the write pointer this cycle
//   push_data  word to store
//   pop        head word consumed this cycle
//   out_valid  registered: buffer holds at least one word
//   out_data   registered head word; stable while not popped
//   occupancy  number of words currently held
// ----------------------------------------------------------------------------
module sc_stream_buf
    import sc_fifo_pkg::*;
#(
    parameter  int DWIDTH = DEF_DWIDTH,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = ptr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  occ_nxt;
    logic [DWIDTH-1:0] head_nxt;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;

        occ_nxt = occupancy;
        if (push && !pop) begin
            occ_nxt = occupancy + CNT_W'(1);
        end else if (pop && !push) begin
            occ_nxt = occupancy - CNT_W'(1);
        end

        // The next head is the word being written this cycle only when the
        // buffer is (or is about to be) empty; otherwise it is already stored.
        // This is a path into the head register, never to the out_data pins.
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = push_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage carries no reset: entries are only read once written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            assert (occupancy <= CNT_W'(DEPTH));
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr    <= rd_ptr_nxt;
            occupancy <= occ_nxt;
            out_valid <= (occ_nxt != '0);
            if (occ_nxt != '0) begin
                out_data <= head_nxt;
            end
        end
    end

endmodule

// File: rtl/sc_fifo_stream_out.sv
// ----------------------------------------------------------------------------
// sc_fifo_stream_out
//
// Downstream adapter for the single-clock FIFO wrapper in standard-read mode.
// Turns the FIFO's "request now, data FIFO_LATENCY cycles later" read port
// into a valid/ready stream with a registered output and full throughput.
// Reads are issued speculatively into a BUF_DEPTH-entry prefetch buffer so
// that every read in flight always has a slot to land in.
//
// Parameters:
//   DWIDTH        word width, must match the upstream FIFO
//   FIFO_LATENCY  cycles from fifo_rdreq to valid fifo_q; 1 or 2
//
// Ports:
//   clock           system clock, rising edge
//   rst             synchronous active-high reset
//   fifo_empty      upstream FIFO empty flag
//   fifo_rdreq      read request to the upstream FIFO (combinational)
//   fifo_q          upstream FIFO read data
//   out_valid       output word valid
//   out_ready       consumer accepts; transfer when out_valid && out_ready
//   out_data        registered output word
//   occupancy       words held in the buffer (reads in flight excluded)
//   xfer_cnt        [SC_FIFO_STREAM_OUT_CNT_EN] completed transfers, mod 2^32
//   empty_read_err  [SC_FIFO_STREAM_OUT_CNT_EN] sticky: read issued while empty
//
// Optional feature macro: SC_FIFO_STREAM_OUT_CNT_EN
// ----------------------------------------------------------------------------
module sc_fifo_stream_out
    import sc_fifo_pkg::*;
#(
    parameter  int DWIDTH       = DEF_DWIDTH,
    parameter  int FIFO_LATENCY = 1,
    localparam int BUF_DEPTH    = buf_depth(FIFO_LATENCY),
    localparam int CNT_W        = cnt_width(FIFO_LATENCY)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    input  logic [DWIDTH-1:0] fifo_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
`ifdef SC_FIFO_STREAM_OUT_CNT_EN
    ,
    output logic [31:0]       xfer_cnt,
    output logic              empty_read_err
`endif
);

    // One extra bit so occupancy + inflight can never wrap before the compare.
    localparam int ACC_W = CNT_W + 1;

    logic [FIFO_LATENCY-1:0] rdreq_pipe;
    logic [CNT_W-1:0]        inflight;
    logic [ACC_W-1:0]        demand;
    logic                    pop;
    logic                    cap;

    assign pop = out_valid && out_ready;
    assign cap = rdreq_pipe[FIFO_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < FIFO_LATENCY; i++) begin
            inflight = inflight + CNT_W'(rdreq_pipe[i]);
        end
    end

    // Counting this cycle's pop frees its slot immediately, which is what
    // keeps a continuously-ready consumer fed every cycle.
    always_comb begin
        demand     = ACC_W'(occupancy) + ACC_W'(inflight) - ACC_W'(pop);
        fifo_rdreq = !rst && !fifo_empty && (demand < ACC_W'(BUF_DEPTH));
    end

    // Stage boundary: read request -> read data arrival (FIFO_LATENCY deep).
    always_ff @(posedge clock) begin
        if (rst) begin
            rdreq_pipe <= '0;
        end else begin
            rdreq_pipe <= (rdreq_pipe << 1) | FIFO_LATENCY'(fifo_rdreq);
        end
    end

    // Stage boundary: captured word -> registered stream head.
    sc_stream_buf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clock     (clock),
        .rst       (rst),
        .push      (cap),
        .push_data (fifo_q),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

`ifdef SC_FIFO_STREAM_OUT_CNT_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            xfer_cnt       <= '0;
            empty_read_err <= 1'b0;
        end else begin
            if (pop) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
            if (fifo_rdreq && fifo_empty) begin
                empty_read_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sc_fifo_stream_out.sv
module tb_sc_fifo_stream_out;
    import sc_fifo_pkg::*;

    localparam int NQ     = 4096;
    localparam int DEPTH0 = 2;   // FIFO_LATENCY 1
    localparam int DEPTH1 = 3;   // FIFO_LATENCY 2

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] rst        = 2'b11;
    logic [1:0] fifo_empty = 2'b11;
    logic [1:0] fifo_rdreq;
    logic [1:0] out_valid;
    logic [1:0] out_ready  = 2'b00;
    word_t      fifo_q0 = '0;
    word_t      fifo_q1 = '0;
    word_t      q1_stage = '0;
    word_t      out_data0, out_data1;
    logic [1:0] occ0, occ1;
`ifdef SC_FIFO_STREAM_OUT_CNT_EN
    logic [31:0] xfer0, xfer1;
    logic        err0, err1;
`endif

    sc_fifo_stream_out #(.DWIDTH(8), .FIFO_LATENCY(1)) u_dut0 (
        .clock      (clock),
        .rst        (rst[0]),
        .fifo_empty (fifo_empty[0]),
        .fifo_rdreq (fifo_rdreq[0]),
        .fifo_q     (fifo_q0),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .out_data   (out_data0),
        .occupancy  (occ0)
`ifdef SC_FIFO_STREAM_OUT_CNT_EN
        ,
        .xfer_cnt       (xfer0),
        .empty_read_err (err0)
`endif
    );

    sc_fifo_stream_out #(.DWIDTH(8), .FIFO_LATENCY(2)) u_dut1 (
        .clock      (clock),
        .rst        (rst[1]),
        .fifo_empty (fifo_empty[1]),
        .fifo_rdreq (fifo_rdreq[1]),
        .fifo_q     (fifo_q1),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .out_data   (out_data1),
        .occupancy  (occ1)
`ifdef SC_FIFO_STREAM_OUT_CNT_EN
        ,
        .xfer_cnt       (xfer1),
        .empty_read_err (err1)
`endif
    );

    // Upstream FIFO models: an array of pushed words with head/tail indices.
    word_t fmem [2][NQ];
    int    fhead [2] = '{0, 0};
    int    ftail [2] = '{0, 0};
    int    exp_idx [2] = '{0, 0};
    int    outcnt [2] = '{0, 0};
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int k, input word_t w);
        fmem[k][ftail[k]] = w;
        ftail[k] = ftail[k] + 1;
    endtask

    // Read port: a request pops the head; data shows up FIFO_LATENCY edges
    // later. Between reads the data bus carries junk.
    always @(posedge clock) begin
        word_t w [2];
        for (int k = 0; k < 2; k++) begin
            w[k] = word_t'($urandom);
            if (fifo_rdreq[k] && (fhead[k] < ftail[k])) begin
                w[k] = fmem[k][fhead[k]];
                fhead[k] = fhead[k] + 1;
            end
        end
        fifo_q0    <= w[0];
        q1_stage   <= w[1];
        fifo_q1    <= q1_stage;
        fifo_empty <= {(fhead[1] == ftail[1]), (fhead[0] == ftail[0])};
    end

    // Scoreboard: outputs must be the pushed words in order; after a reset
    // the stream resumes at the first word still inside the FIFO.
    logic [1:0] prev_hold = 2'b00;
    word_t      prev_data [2];
    always @(negedge clock) begin
        logic  vld;
        word_t data;
        int    occ, depth;
        for (int k = 0; k < 2; k++) begin
            vld   = out_valid[k];
            data  = (k == 0) ? out_data0 : out_data1;
            occ   = (k == 0) ? int'(occ0) : int'(occ1);
            depth = (k == 0) ? DEPTH0 : DEPTH1;
            if (rst[k]) begin
                exp_idx[k]   = fhead[k];
                prev_hold[k] = 1'b0;
            end else begin
                chk($sformatf("occ_bound%0d", k), 32'(occ <= depth), 32'd1);
                chk($sformatf("empty_read%0d", k), 32'(fifo_rdreq[k] && fifo_empty[k]), 32'd0);
                if (prev_hold[k]) chk($sformatf("hold%0d", k), 32'(data), 32'(prev_data[k]));
                if (vld && out_ready[k]) begin
                    chk($sformatf("order%0d", k), 32'(data), 32'(fmem[k][exp_idx[k]]));
                    exp_idx[k] = exp_idx[k] + 1;
                    outcnt[k]  = outcnt[k] + 1;
                end
                prev_hold[k] = vld && !out_ready[k];
            end
            prev_data[k] = data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, t, pushed0, pushed1;

        // Reset state, FIFO 0 preloaded with 0x01..0x10
        for (int i = 1; i <= 16; i++) push(0, word_t'(i));
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid0", 32'(out_valid[0]), 32'd0);
        chk("rst_valid1", 32'(out_valid[1]), 32'd0);
        chk("rst_occ0", 32'(occ0), 32'd0);
        chk("rst_occ1", 32'(occ1), 32'd0);
        chk("rst_data0", 32'(out_data0), 32'd0);
        chk("rst_rdreq0", 32'(fifo_rdreq[0]), 32'd0);

        // Steady flow, latency 1
        @(posedge clock); #1;
        out_ready = 2'b01;
        rst = 2'b00;
        @(negedge clock);
        chk("sf_rdreq_c0", 32'(fifo_rdreq[0]), 32'd1);
        chk("sf_valid_c0", 32'(out_valid[0]), 32'd0);
        @(negedge clock);
        chk("sf_valid_c1", 32'(out_valid[0]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            chk("sf_valid", 32'(out_valid[0]), 32'd1);
            chk("sf_data", 32'(out_data0), 32'(i + 1));
        end
        @(negedge clock);
        chk("sf_valid_end", 32'(out_valid[0]), 32'd0);

        // Back-pressure, latency 1
        @(posedge clock); #1;
        out_ready[0] = 1'b0;
        for (int i = 1; i <= 8; i++) push(0, word_t'(i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i >= 4) begin
                chk("bp_occ", 32'(occ0), 32'd2);
                chk("bp_data", 32'(out_data0), 32'h01);
                chk("bp_rdreq", 32'(fifo_rdreq[0]), 32'd0);
            end
        end
        n0 = outcnt[0];
        @(posedge clock); #1;
        out_ready[0] = 1'b1;
        repeat (20) @(negedge clock);
        chk("bp_count", 32'(outcnt[0] - n0), 32'd8);

        // Latency 2 flow
        @(posedge clock); #1;
        out_ready[1] = 1'b1;
        for (int i = 0; i < 5; i++) push(1, word_t'(8'h21 + i));
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!fifo_rdreq[1] && t < 20);
        chk("l2_rdreq_seen", 32'(fifo_rdreq[1]), 32'd1);
        chk("l2_valid_c0", 32'(out_valid[1]), 32'd0);
        @(negedge clock);
        chk("l2_valid_c1", 32'(out_valid[1]), 32'd0);
        @(negedge clock);
        chk("l2_valid_c2", 32'(out_valid[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("l2_valid", 32'(out_valid[1]), 32'd1);
            chk("l2_data", 32'(out_data1), 32'(8'h21 + i));
        end
        @(negedge clock);
        chk("l2_valid_end", 32'(out_valid[1]), 32'd0);

        // Reset mid-stream, latency 2: two buffered, one in flight
        @(posedge clock); #1;
        out_ready[1] = 1'b0;
        for (int i = 0; i < 6; i++) push(1, word_t'(8'h31 + i));
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!fifo_rdreq[1] && t < 20);
        chk("mr_rdreq_seen", 32'(fifo_rdreq[1]), 32'd1);
        repeat (4) @(posedge clock);
        #1;
        chk("mr_setup_occ", 32'(occ1), 32'd2);
        rst[1] = 1'b1;
        #1;
        chk("mr_rdreq_in_rst", 32'(fifo_rdreq[1]), 32'd0);
        @(posedge clock); #1;
        rst[1] = 1'b0;
        @(negedge clock);
        chk("mr_valid", 32'(out_valid[1]), 32'd0);
        chk("mr_occ", 32'(occ1), 32'd0);
        @(posedge clock); #1;
        out_ready[1] = 1'b1;
        n1 = outcnt[1];
        t = 0;
        while (!out_valid[1] && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("mr_resume_valid", 32'(out_valid[1]), 32'd1);
        chk("mr_resume_data", 32'(out_data1), 32'h34);
        repeat (10) @(negedge clock);
        chk("mr_resume_count", 32'(outcnt[1] - n1), 32'd3);

        // Random stream on both instances
        n0 = outcnt[0];
        n1 = outcnt[1];
        pushed0 = 0;
        pushed1 = 0;
        @(posedge clock); #1;
        while (pushed0 < 1000 || pushed1 < 1000) begin
            if (pushed0 < 1000 && $urandom_range(0, 2) != 0) begin
                push(0, word_t'($urandom));
                pushed0++;
            end
            if (pushed1 < 1000 && $urandom_range(0, 2) != 0) begin
                push(1, word_t'($urandom));
                pushed1++;
            end
            out_ready = 2'($urandom);
            @(posedge clock); #1;
        end
        out_ready = 2'b11;
        t = 0;
        while ((outcnt[0] - n0 < 1000 || outcnt[1] - n1 < 1000) && t < 5000) begin
            @(posedge clock); #1;
            t++;
        end
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("rand_count0", 32'(outcnt[0] - n0), 32'd1000);
        chk("rand_count1", 32'(outcnt[1] - n1), 32'd1000);
        chk("rand_drained0", 32'(ftail[0] - fhead[0]), 32'd0);

`ifdef SC_FIFO_STREAM_OUT_CNT_EN
        // Transfer counter and empty-read flag
        @(posedge clock); #1;
        rst[0] = 1'b1;
        @(posedge clock); #1;
        rst[0] = 1'b0;
        @(negedge clock);
        chk("cnt_after_rst", xfer0, 32'd0);
        n0 = outcnt[0];
        @(posedge clock); #1;
        for (int i = 0; i < 37; i++) push(0, word_t'(8'h50 + i));
        t = 0;
        while (outcnt[0] - n0 < 37 && t < 200) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        chk("cnt_37", xfer0, 32'd37);
        chk("err0_clear", 32'(err0), 32'd0);
        chk("err1_clear", 32'(err1), 32'd0);
        @(posedge clock); #1;
        rst[0] = 1'b1;
        @(posedge clock); #1;
        rst[0] = 1'b0;
        @(negedge clock);
        chk("cnt_rst_zero", xfer0, 32'd0);
        chk("err0_after_rst", 32'(err0), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_fifo_stream_out.md
Name: sc_fifo_stream_out

Overview:
- Downstream adapter for the single-clock FIFO wrapper (standard-read mode, rdreq/q with fixed read latency).
- Converts the FIFO's pop-and-wait interface into a valid/ready stream with full throughput and a registered output.
- Uses a small prefetch/skid buffer sized to cover the FIFO read latency.
- Sits between each sc_fifo instance and its consumer in the bbqflies datapath.

Parameters:
- DWIDTH, 8, data word width; must match the upstream FIFO.
- FIFO_LATENCY, 1, cycles from accepted fifo_rdreq to valid fifo_q; legal values 1 or 2 (2 = FIFO output register enabled).
- BUF_DEPTH, FIFO_LATENCY+1, localparam; prefetch buffer entries.
- CNT_W, $clog2(BUF_DEPTH+1), localparam; occupancy counter width.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_rdreq  out  1  read request to upstream FIFO.
- fifo_q  in  DWIDTH  upstream FIFO read data; valid FIFO_LATENCY cycles after an issued rdreq.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_data  out  DWIDTH  output word; registered, held stable while out_valid && !out_ready.
- occupancy  out  CNT_W  words held in the buffer; in-flight reads excluded.

Behaviour:
- Reset values (synchronous, rst=1 at a clock edge): out_valid=0, out_data=0, occupancy=0, in-flight pipe cleared, buffer pointers 0. fifo_rdreq is forced 0 while rst=1.
- Transfer rules:
  - pop = out_valid && out_ready.
  - inflight = number of 1s in the FIFO_LATENCY-deep rdreq shift pipe.
- Issue rule (combinational; out_ready-to-fifo_rdreq path is allowed):
  - fifo_rdreq = !rst && !fifo_empty && (occupancy + inflight - pop) < BUF_DEPTH.
  - Never issues while fifo_empty=1; this does not rely on FIFO underflow protection.
- Capture: when the pipe tail bit is 1, fifo_q is written at the buffer write pointer that cycle. Overflow cannot occur by construction; the verification assertion is occupancy <= BUF_DEPTH.
- Buffer: circular, BUF_DEPTH entries, read and write pointers wrap at BUF_DEPTH. out_data is the head entry, delivered from a register with no combinational path from fifo_q.
- occupancy update, with cap = capture this cycle:
  - +1 on cap && !pop.
  - -1 on pop && !cap.
  - Unchanged on both or neither.
  - out_valid = (occupancy != 0), registered.
- Latency: rdreq at cycle t -> fifo_q at t+FIFO_LATENCY -> out_valid at t+FIFO_LATENCY+1. For FIFO_LATENCY=1, first word appears 2 cycles after fifo_empty falls.
- Throughput: with fifo non-empty and out_ready held 1, one word per cycle sustained after the initial fill.
- Order: strict FIFO order preserved; no duplication or loss outside reset.
- Back-pressure: out_ready=0 stops issue once occupancy+inflight reaches BUF_DEPTH; all in-flight words still land.
- Simultaneous capture and pop with buffer full: legal; occupancy unchanged.
- Reset mid-operation: the upstream FIFO is not reset. Words popped but still in flight or buffered are discarded. This loss is accepted system behaviour, and the bench must not flag it.

Optional Feature:
- Macro: SC_FIFO_STREAM_OUT_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [31:0]: count of completed transfers (pop).
  - Reset to 0 by rst; wraps modulo 2^32.
  - Adds a sticky output port empty_read_err, set if fifo_rdreq && fifo_empty is ever observed; this is a debug check that should never fire.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package sc_fifo_pkg:
  - localparam functions for BUF_DEPTH and CNT_W.
  - Shared constant MAX_FIFO_LATENCY = 2.
  - Typedef word_t logic [DWIDTH-1:0], parameterised via a package-level default of 8.
- Sub-module sc_stream_buf: the BUF_DEPTH-entry circular register buffer with push/pop/occupancy. The top level keeps the issue logic and the in-flight shift pipe.

Test Plan:
- Steady flow: FIFO model preloaded with 0x01..0x10, FIFO_LATENCY=1, out_ready=1 -> first out_valid 2 cycles after rst falls; 16 words 0x01..0x10 on 16 consecutive cycles; fifo_rdreq never high while fifo_empty=1.
- Back-pressure: 8 words queued, out_ready=0 for 10 cycles then 1 -> occupancy saturates at 2, out_data held at 0x01; afterwards words 0x01..0x08 in order, none lost.
- Latency 2: FIFO_LATENCY=2, 5 words, out_ready=1 -> first out_valid 3 cycles after first rdreq; occupancy never exceeds 3; then one word per cycle.
- Random ready: 1000 random words, out_ready random 50%, random FIFO refill gaps -> scoreboard order match, occupancy <= BUF_DEPTH every cycle.
- Reset mid-stream: assert rst for 1 cycle while 2 words are buffered and 1 in flight -> next cycle out_valid=0, occupancy=0, rdreq=0; stream resumes with the next FIFO word (discarded words not emitted).
- With SC_FIFO_STREAM_OUT_CNT_EN: 37 transfers -> xfer_cnt=37; rst -> 0; empty_read_err remains 0 throughout.
